sa_pe: RTL and testbench

Parametrised weight-stationary processing element for the systolic MAC array. Each PE captures a weight from its north bus during a load phase, then in compute phase multiplies streaming west data by that weight, adds the north partial sum and drives the result south. West data is passed east with one register of skew. Unlike the first-generation PE, this one has configurable widths, signed mode, valid qualifiers, reset, and on-demand weight reload.

---
 rtl/sa_pe_pkg.sv | 34 +++
 rtl/sa_pe_mac_stage.sv | 125 ++++++++++++
 rtl/sa_pe.sv | 142 ++++++++++++++
 tb/tb_sa_pe.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pe_pkg.sv
// ============================================================================
// Module   : sa_pe_pkg
// Brief    : Shared types, default widths and saturation bound helpers for sa_pe.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sa_pe_pkg;

  typedef enum logic [0:0] {
    ST_LOAD    = 1'b0,
    ST_COMPUTE = 1'b1
  } pe_state_t;

  localparam int c_data_w     = 8;
  localparam int c_weight_w   = 8;
  localparam int c_acc_w      = 32;
  localparam int c_load_count = 1;
  localparam int c_sat_max_w  = 64;

  // Bounds are returned in a 64-bit container; callers slice the low w bits.
  function automatic logic [c_sat_max_w-1:0] sat_max(input int w, input bit sgn);
    if (sgn) return (64'd1 << (w - 1)) - 64'd1;
    else     return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [c_sat_max_w-1:0] sat_min(input int w, input bit sgn);
    if (sgn) return 64'd1 << (w - 1);
    else     return '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sa_pe_mac_stage.sv
// ============================================================================
// Module   : pe_mac_stage
// Brief    : Multiply register, extend-and-add stage and south output register.
//            Saturating add is enabled by defining PE_SAT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pe_mac_stage
  import sa_pe_pkg::*;
#(
  parameter int DATA_W   = c_data_w,
  parameter int WEIGHT_W = c_weight_w,
  parameter int ACC_W    = c_acc_w,
  parameter int SIGNED   = 0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_mul_en,
  input  logic [DATA_W-1:0]   i_west_data,
  input  logic [WEIGHT_W-1:0] i_weight,
  input  logic                i_acc_en,
  input  logic [ACC_W-1:0]    i_north_psum,
  input  logic                i_fwd_en,
  input  logic [ACC_W-1:0]    i_fwd_data,
  output logic [ACC_W-1:0]    o_south_psum,
  output logic                o_south_valid,
  output logic                o_sat
);

  localparam int c_prod_w = DATA_W + WEIGHT_W;

  logic [c_prod_w-1:0] w_prod;
  logic [c_prod_w-1:0] r_prod;
  logic                r_prod_valid;
  logic [ACC_W-1:0]    w_prod_x;
  logic [ACC_W-1:0]    w_sum;
  logic [ACC_W-1:0]    r_south_psum;
  logic                r_south_valid;

  if (SIGNED != 0) begin : g_signed
    logic signed [c_prod_w-1:0] w_a_s;
    logic signed [c_prod_w-1:0] w_b_s;
    assign w_a_s    = c_prod_w'($signed(i_west_data));
    assign w_b_s    = c_prod_w'($signed(i_weight));
    assign w_prod   = w_a_s * w_b_s;
    assign w_prod_x = ACC_W'($signed(r_prod));
  end else begin : g_unsigned
    assign w_prod   = c_prod_w'(i_west_data) * c_prod_w'(i_weight);
    assign w_prod_x = ACC_W'(r_prod);
  end

`ifdef PE_SAT_EN
  localparam logic [c_sat_max_w-1:0] c_hi = sat_max(ACC_W, SIGNED != 0);
  localparam logic [c_sat_max_w-1:0] c_lo = sat_min(ACC_W, SIGNED != 0);

  logic [ACC_W:0] w_a;
  logic [ACC_W:0] w_b;
  logic [ACC_W:0] w_sum_x;
  logic           w_clamp;
  logic           r_sat;

  // One guard bit exposes overflow in either signedness.
  always_comb begin
    w_a     = {1'b0, w_prod_x};
    w_b     = {1'b0, i_north_psum};
    w_clamp = 1'b0;
    if (SIGNED != 0) begin
      w_a = {w_prod_x[ACC_W-1], w_prod_x};
      w_b = {i_north_psum[ACC_W-1], i_north_psum};
    end
    w_sum_x = w_a + w_b;
    w_sum   = w_sum_x[ACC_W-1:0];
    if (SIGNED != 0) begin
      if (w_sum_x[ACC_W] != w_sum_x[ACC_W-1]) begin
        w_clamp = 1'b1;
        w_sum   = w_sum_x[ACC_W] ? c_lo[ACC_W-1:0] : c_hi[ACC_W-1:0];
      end
    end else if (w_sum_x[ACC_W]) begin
      w_clamp = 1'b1;
      w_sum   = c_hi[ACC_W-1:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sat <= 1'b0;
    end else if (i_acc_en && r_prod_valid && w_clamp) begin
      r_sat <= 1'b1;
    end
  end

  assign o_sat = r_sat;
`else
  assign w_sum = w_prod_x + i_north_psum;
  assign o_sat = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prod        <= '0;
      r_prod_valid  <= 1'b0;
      r_south_psum  <= '0;
      r_south_valid <= 1'b0;
    end else begin
      r_prod_valid <= i_mul_en;
      if (i_mul_en) r_prod <= w_prod;
      if (i_fwd_en) begin
        r_south_psum  <= i_fwd_data;
        r_south_valid <= 1'b1;
      end else if (i_acc_en) begin
        r_south_valid <= r_prod_valid;
        if (r_prod_valid) r_south_psum <= w_sum;
      end else begin
        r_south_valid <= 1'b0;
      end
    end
  end

  assign o_south_psum  = r_south_psum;
  assign o_south_valid = r_south_valid;

endmodule

`default_nettype wire

// File: rtl/sa_pe.sv
// ============================================================================
// Module   : sa_pe
// Brief    : Weight-stationary systolic PE: load FSM, weight register, east skew.
//            Define PE_SAT_EN for a saturating accumulate with sticky o_sat.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sa_pe
  import sa_pe_pkg::*;
#(
  parameter int DATA_W     = c_data_w,
  parameter int WEIGHT_W   = c_weight_w,
  parameter int ACC_W      = c_acc_w,
  parameter int LOAD_COUNT = c_load_count,
  parameter int SIGNED     = 0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [DATA_W-1:0]   i_west_data,
  input  logic                i_west_valid,
  output logic [DATA_W-1:0]   o_east_data,
  output logic                o_east_valid,
  input  logic [ACC_W-1:0]    i_north_psum,
  input  logic                i_north_valid,
  output logic [ACC_W-1:0]    o_south_psum,
  output logic                o_south_valid,
  input  logic                i_reload,
  output logic                o_compute,
  output logic [WEIGHT_W-1:0] o_weight,
  output logic                o_sat
);

  localparam int c_cnt_w = (LOAD_COUNT > 1) ? $clog2(LOAD_COUNT) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(LOAD_COUNT - 1);

  if (LOAD_COUNT < 1) begin : g_bad_load_count
    $error("sa_pe: LOAD_COUNT must be >= 1");
  end
  if (DATA_W + WEIGHT_W > ACC_W) begin : g_bad_acc_w
    $error("sa_pe: DATA_W + WEIGHT_W must not exceed ACC_W");
  end

  pe_state_t           r_state;
  pe_state_t           w_state_nxt;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_cnt_w-1:0]  w_cnt_nxt;
  logic [WEIGHT_W-1:0] r_weight;
  logic [DATA_W-1:0]   r_east_data;
  logic                r_east_valid;
  logic                w_is_compute;
  logic                w_beat;
  logic                w_mul_en;
  logic                w_acc_en;
  logic [ACC_W-1:0]    w_fwd_data;

  assign w_is_compute = (r_state == ST_COMPUTE);
  // A reload in LOAD wins over a simultaneous beat: the beat is dropped.
  assign w_beat       = !w_is_compute && i_north_valid && !i_reload;
  assign w_mul_en     = w_is_compute && i_west_valid && !i_reload;
  assign w_acc_en     = w_is_compute && !i_reload;
  assign w_fwd_data   = ACC_W'(i_north_psum[WEIGHT_W-1:0]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_LOAD;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_LOAD: begin
        if (i_reload) begin
          w_cnt_nxt = '0;
        end else if (i_north_valid) begin
          if (r_cnt == c_last) begin
            w_state_nxt = ST_COMPUTE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      ST_COMPUTE: begin
        if (i_reload) begin
          w_state_nxt = ST_LOAD;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_LOAD;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_weight     <= '0;
      r_east_data  <= '0;
      r_east_valid <= 1'b0;
    end else begin
      if (w_beat) r_weight <= i_north_psum[WEIGHT_W-1:0];
      r_east_data  <= i_west_data;
      r_east_valid <= i_west_valid;
    end
  end

  pe_mac_stage #(
    .DATA_W   (DATA_W),
    .WEIGHT_W (WEIGHT_W),
    .ACC_W    (ACC_W),
    .SIGNED   (SIGNED)
  ) u_mac (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_mul_en      (w_mul_en),
    .i_west_data   (i_west_data),
    .i_weight      (r_weight),
    .i_acc_en      (w_acc_en),
    .i_north_psum  (i_north_psum),
    .i_fwd_en      (w_beat),
    .i_fwd_data    (w_fwd_data),
    .o_south_psum  (o_south_psum),
    .o_south_valid (o_south_valid),
    .o_sat         (o_sat)
  );

  assign o_east_data  = r_east_data;
  assign o_east_valid = r_east_valid;
  assign o_compute    = w_is_compute;
  assign o_weight     = r_weight;

endmodule

`default_nettype wire

// File: tb/tb_sa_pe.sv
// ============================================================================
// Module   : tb_sa_pe
// Brief    : Scoreboard bench for sa_pe across three configurations.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sa_pe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // DUT A: unsigned, ACC_W 32, LOAD_COUNT 3
  logic [7:0]  a_wd, a_ed, a_wt;
  logic        a_wv, a_ev, a_nv, a_sv, a_rl, a_cmp, a_sat;
  logic [31:0] a_np, a_sp;
  // DUT B: signed, ACC_W 32, LOAD_COUNT 1
  logic [7:0]  b_wd, b_ed, b_wt;
  logic        b_wv, b_ev, b_nv, b_sv, b_rl, b_cmp, b_sat;
  logic [31:0] b_np, b_sp;
  // DUT C: unsigned, ACC_W 16, LOAD_COUNT 1
  logic [7:0]  c_wd, c_ed, c_wt;
  logic        c_wv, c_ev, c_nv, c_sv, c_rl, c_cmp, c_sat;
  logic [15:0] c_np, c_sp;

  int checks = 0;
  int errors = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [15:0] qc[$];
  logic [31:0] exp_a, exp_b;
  logic [15:0] exp_c;

`ifdef PE_SAT_EN
  localparam logic [15:0] c_ovf_psum = 16'hFFFF;
  localparam logic        c_ovf_sat  = 1'b1;
`else
  localparam logic [15:0] c_ovf_psum = 16'h01E9;
  localparam logic        c_ovf_sat  = 1'b0;
`endif

  sa_pe #(.LOAD_COUNT(3)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_west_data(a_wd), .i_west_valid(a_wv),
    .o_east_data(a_ed), .o_east_valid(a_ev), .i_north_psum(a_np), .i_north_valid(a_nv),
    .o_south_psum(a_sp), .o_south_valid(a_sv), .i_reload(a_rl), .o_compute(a_cmp),
    .o_weight(a_wt), .o_sat(a_sat)
  );

  sa_pe #(.SIGNED(1)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_west_data(b_wd), .i_west_valid(b_wv),
    .o_east_data(b_ed), .o_east_valid(b_ev), .i_north_psum(b_np), .i_north_valid(b_nv),
    .o_south_psum(b_sp), .o_south_valid(b_sv), .i_reload(b_rl), .o_compute(b_cmp),
    .o_weight(b_wt), .o_sat(b_sat)
  );

  sa_pe #(.ACC_W(16)) u_dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_west_data(c_wd), .i_west_valid(c_wv),
    .o_east_data(c_ed), .o_east_valid(c_ev), .i_north_psum(c_np), .i_north_valid(c_nv),
    .o_south_psum(c_sp), .o_south_valid(c_sv), .i_reload(c_rl), .o_compute(c_cmp),
    .o_weight(c_wt), .o_sat(c_sat)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // South-path monitors: every valid output must match the head of its queue.
  always @(negedge clk) begin
    if (a_sv) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL south_a: got unexpected valid psum %0h, required no output", a_sp);
      end else begin
        exp_a = qa.pop_front();
        if (a_sp !== exp_a) begin
          errors++;
          $display("FAIL south_a: got %0h, required %0h", a_sp, exp_a);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b_sv) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL south_b: got unexpected valid psum %0h, required no output", b_sp);
      end else begin
        exp_b = qb.pop_front();
        if (b_sp !== exp_b) begin
          errors++;
          $display("FAIL south_b: got %0h, required %0h", b_sp, exp_b);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (c_sv) begin
      checks++;
      if (qc.size() == 0) begin
        errors++;
        $display("FAIL south_c: got unexpected valid psum %0h, required no output", c_sp);
      end else begin
        exp_c = qc.pop_front();
        if (c_sp !== exp_c) begin
          errors++;
          $display("FAIL south_c: got %0h, required %0h", c_sp, exp_c);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    {a_wd, a_wv, a_np, a_nv, a_rl} = '0;
    {b_wd, b_wv, b_np, b_nv, b_rl} = '0;
    {c_wd, c_wv, c_np, c_nv, c_rl} = '0;
    step();
    step();
    chk("rst_a_psum", a_sp, 0);
    chk("rst_a_svalid", a_sv, 0);
    chk("rst_a_compute", a_cmp, 0);
    chk("rst_a_weight", a_wt, 0);
    chk("rst_a_east", a_ed, 0);
    chk("rst_a_sat", a_sat, 0);
    chk("rst_c_psum", c_sp, 0);
    rst_n = 1'b1;
    step();

    // Three-beat load; upper psum bits must not reach the weight or south
    a_nv = 1'b1;
    a_np = 32'h11;          qa.push_back(32'h11); step(); chk("load1_compute", a_cmp, 0);
    a_np = 32'h1234_5622;   qa.push_back(32'h22); step(); chk("load2_compute", a_cmp, 0);
    a_np = 32'h33;          qa.push_back(32'h33); step();
    a_nv = 1'b0; a_np = 0;
    chk("load3_compute", a_cmp, 1);
    chk("load3_weight", a_wt, 8'h33);

    a_rl = 1'b1; step(); a_rl = 1'b0;
    chk("reload_compute", a_cmp, 0);
    chk("reload_weight_held", a_wt, 8'h33);

    a_nv = 1'b1;
    a_np = 32'd1; qa.push_back(32'd1); step();
    a_np = 32'd2; qa.push_back(32'd2); step();
    a_np = 32'd5; qa.push_back(32'd5); step();
    a_nv = 1'b0; a_np = 0;
    chk("load_w5_weight", a_wt, 8'd5);

    // 7*5 + 100
    a_wd = 8'd7; a_wv = 1'b1; step();
    chk("east_data", a_ed, 8'd7);
    chk("east_valid", a_ev, 1);
    a_wv = 1'b0; a_np = 32'd100; qa.push_back(32'd135); step();
    chk("east_valid_low", a_ev, 0);

    // Back-to-back: 3*5+10, 4*5+20
    a_wd = 8'd3; a_wv = 1'b1; a_np = 0; step();
    a_wd = 8'd4; a_np = 32'd10; qa.push_back(32'd25); step();
    a_wv = 1'b0; a_np = 32'd20; qa.push_back(32'd40); step();
    a_np = 32'd77; step();
    chk("hold_psum", a_sp, 32'd40);
    chk("hold_svalid", a_sv, 0);

    // Reload with a product in flight drops it
    a_wd = 8'd9; a_wv = 1'b1; step();
    a_wv = 1'b0; a_rl = 1'b1; a_np = 32'd50; step();
    a_rl = 1'b0;
    chk("inflight_compute", a_cmp, 0);
    chk("inflight_svalid", a_sv, 0);
    chk("inflight_weight", a_wt, 8'd5);
    step();
    chk("inflight_weight_idle", a_wt, 8'd5);
    a_nv = 1'b1;
    a_np = 32'd8; qa.push_back(32'd8); step();
    chk("new_beat_weight", a_wt, 8'd8);
    a_np = 32'd8; qa.push_back(32'd8); step();
    a_np = 32'd6; qa.push_back(32'd6); step();
    a_nv = 1'b0; a_np = 0;
    chk("reload_done_compute", a_cmp, 1);

    // Signed: weight -2
    b_nv = 1'b1; b_np = 32'hFE; qb.push_back(32'hFE); step();
    b_nv = 1'b0; b_np = 0;
    chk("b_compute", b_cmp, 1);
    chk("b_weight", b_wt, 8'hFE);
    b_wd = 8'h03; b_wv = 1'b1; step();
    b_wv = 1'b0; b_np = 32'd10; qb.push_back(32'd4); step();
    b_wd = 8'h80; b_wv = 1'b1; b_np = 0; step();
    b_wd = 8'h05; b_np = 32'hFFFF_FFFA; qb.push_back(32'd250); step();
    b_wv = 1'b0; b_np = 32'd3; qb.push_back(32'hFFFF_FFF9); step();
    b_np = 0; step();

    // ACC_W=16 overflow: 255*255 + 1000 = 0x101E9
    c_nv = 1'b1; c_np = 16'h00FF; qc.push_back(16'h00FF); step();
    c_nv = 1'b0; c_np = 0;
    chk("c_weight", c_wt, 8'hFF);
    chk("c_sat_before", c_sat, 0);
    c_wd = 8'hFF; c_wv = 1'b1; step();
    c_wv = 1'b0; c_np = 16'd1000; qc.push_back(c_ovf_psum); step();
    chk("c_sat_after", c_sat, c_ovf_sat);
    c_wd = 8'd2; c_wv = 1'b1; c_np = 0; step();
    c_wv = 1'b0; c_np = 16'd3; qc.push_back(16'd513); step();
    chk("c_sat_sticky", c_sat, c_ovf_sat);
    c_np = 0; step();

    // Asynchronous reset mid-compute (A holds weight 6, south psum 6)
    a_wd = 8'd2; a_wv = 1'b1; step();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_psum", a_sp, 0);
    chk("arst_svalid", a_sv, 0);
    chk("arst_east", a_ed, 0);
    chk("arst_east_valid", a_ev, 0);
    chk("arst_compute", a_cmp, 0);
    chk("arst_weight", a_wt, 0);
    a_wv = 1'b0;
    #2 rst_n = 1'b1;
    step();
    a_nv = 1'b1; a_np = 32'h44; qa.push_back(32'h44); step();
    a_nv = 1'b0; a_np = 0;
    chk("post_rst_weight", a_wt, 8'h44);
    chk("post_rst_compute", a_cmp, 0);
    step();
    step();

    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);
    chk("drain_c", qc.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
